// File: rtl/nzr_coder_if.sv
// Symbol request / NZR line bundle between the GRB sequencer (master) and
// the NZR coder (slave).
interface nzr_coder_if;
  logic [1:0] qmode;
  logic       StartCoding;
  logic       dout;
  logic       bdone;

  modport master (output qmode, StartCoding, input dout, bdone);
  modport slave  (input qmode, StartCoding, output dout, bdone);
endinterface

// File: rtl/nzr_coder.sv
// NZR line coder for addressable LED strings: data-0/data-1 symbols and a reset/latch code.
// Optional macro NZR_BUSY_EN adds a busy output, high whenever the coder is not idle.
module nzr_coder #(
  parameter int unsigned T0H  = 20,
  parameter int unsigned T1H  = 40,
  parameter int unsigned TBIT = 63,
  parameter int unsigned TRES = 2600
) (
  input logic        clk,
  input logic        reset,
  nzr_coder_if.slave bus
`ifdef NZR_BUSY_EN
  ,
  output logic       busy
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, RES} state_t;

  localparam logic [11:0] C_T0H = 12'(T0H);
  localparam logic [11:0] C_T1H = 12'(T1H);
  localparam logic [11:0] C_L0  = 12'(TBIT - 1 - T0H);
  localparam logic [11:0] C_L1  = 12'(TBIT - 1 - T1H);
  localparam logic [11:0] C_RES = 12'(TRES);

  state_t      r_state, w_state_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;
  logic        r_pend, w_pend_nxt;
  logic        r_one, w_one_nxt;
  logic        w_last;

  // The counter is loaded with the phase length and each phase ends when it reads 1.
  assign w_last = (r_cnt == 12'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_one_nxt   = r_one;
    case (r_state)
      IDLE: begin
        if (bus.StartCoding) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pend_nxt = 1'b0;
        if (bus.qmode[1]) begin
          w_state_nxt = RES;
          w_cnt_nxt   = C_RES;
        end else begin
          w_state_nxt = HIGH;
          w_one_nxt   = bus.qmode[0];
          w_cnt_nxt   = bus.qmode[0] ? C_T1H : C_T0H;
        end
      end
      HIGH: begin
        if (w_last) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = r_one ? C_L1 : C_L0;
        end else begin
          w_cnt_nxt = r_cnt - 12'd1;
        end
      end
      LOW: begin
        w_cnt_nxt = r_cnt - 12'd1;
        if (w_last) w_state_nxt = LOAD;
      end
      RES: begin
        w_cnt_nxt = r_cnt - 12'd1;
        if (bus.StartCoding) w_pend_nxt = 1'b1;
        // A start seen in the final RES cycle still chains straight into LOAD.
        if (w_last) begin
          if (r_pend || bus.StartCoding) begin
            w_state_nxt = LOAD;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_one   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_one   <= w_one_nxt;
    end
  end

  assign bus.dout  = (r_state == HIGH);
  assign bus.bdone = (r_state == LOW) && w_last;

`ifdef NZR_BUSY_EN
  assign busy = (r_state != IDLE);
`endif

endmodule

// File: tb/tb_nzr_coder.sv
// Randomised scoreboard bench for nzr_coder: a per-cycle expected line is built from symbol
// timing rules, played out as stimulus, and checked by an independent monitor.
module tb_nzr_coder;

  localparam int unsigned P_T0H  = 20;
  localparam int unsigned P_T1H  = 40;
  localparam int unsigned P_TBIT = 63;
  localparam int unsigned P_TRES = 2600;

  typedef struct packed {
    logic       dout;
    logic       bdone;
    logic       busy;
    logic       start;
    logic       rst;
    logic [1:0] qm;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
`ifdef NZR_BUSY_EN
  logic busy;
`endif

  nzr_coder_if bus ();

  nzr_coder #(
    .T0H (P_T0H),
    .T1H (P_T1H),
    .TBIT(P_TBIT),
    .TRES(P_TRES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef NZR_BUSY_EN
    ,
    .busy (busy)
`endif
  );

  always #5 clk = ~clk;

  ent_t plan[$];
  ent_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   running = 1'b0;

  function automatic logic [1:0] rq();
    return 2'($urandom_range(3, 0));
  endfunction

  function automatic logic spur();
    return ($urandom_range(7, 0) == 0);
  endfunction

  task automatic add(input logic d, input logic b, input logic bz, input logic st,
                     input logic rs, input logic [1:0] q);
    ent_t e;
    e.dout = d; e.bdone = b; e.busy = bz; e.start = st; e.rst = rs; e.qm = q;
    plan.push_back(e);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rq());
  endtask

  task automatic add_start();
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rq());
  endtask

  // Data symbol: one LOAD cycle, THx high cycles, then low until TBIT total, bdone on the last.
  task automatic add_data(input logic one);
    int th;
    int tl;
    th = one ? P_T1H : P_T0H;
    tl = P_TBIT - 1 - th;
    add(1'b0, 1'b0, 1'b1, spur(), 1'b1, {1'b0, one});
    for (int i = 0; i < th; i++) add(1'b1, 1'b0, 1'b1, spur(), 1'b1, rq());
    for (int i = 0; i < tl; i++) add(1'b0, (i == tl - 1), 1'b1, spur(), 1'b1, rq());
  endtask

  // Reset code; pidx >= 0 places a StartCoding pulse at that RES cycle.
  task automatic add_res(input int pidx);
    add(1'b0, 1'b0, 1'b1, spur(), 1'b1, {1'b1, 1'($urandom_range(1, 0))});
    for (int i = 0; i < P_TRES; i++) add(1'b0, 1'b0, 1'b1, (i == pidx), 1'b1, rq());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        cyc++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL underflow cycle %0d: no expected entry queued", cyc);
        end else begin
          ent_t e;
          logic [2:0] act, exp_v;
          e = sb_q.pop_front();
`ifdef NZR_BUSY_EN
          act   = {bus.dout, bus.bdone, busy};
          exp_v = {e.dout, e.bdone, e.busy};
`else
          act   = {bus.dout, bus.bdone, 1'b0};
          exp_v = {e.dout, e.bdone, 1'b0};
`endif
          if (act !== exp_v) begin
            n_err++;
            $display("FAIL line cycle %0d: dout/bdone/busy got %b required %b", cyc, act, exp_v);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.StartCoding = 1'b0;
    bus.qmode = 2'b00;

    // Power-on reset, then quiet idle.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rq());
    add_idle(4);

    // Chained data symbols, reset code with a start pending from RES cycle 100.
    add_start();
    add_data(1'b1);
    add_data(1'b0);
    for (int i = 0; i < 3; i++) add_data(1'($urandom_range(1, 0)));
    add_res(99);
    add_data(1'($urandom_range(1, 0)));
    add_data(1'($urandom_range(1, 0)));
    add_res(P_TRES - 1);
    add_data(1'b1);
    add_res(-1);
    add_idle(5);

    // Reset asserted at cycle 10 while HIGH, with StartCoding coincident (discarded).
    add_start();
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rq());
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rq());
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rq());
    add_idle(3);
    add_start();
    add_data(1'b0);
    add_data(1'b1);
    add_res(-1);
    add_idle(3);

    // Random sessions.
    for (int s = 0; s < 3; s++) begin
      int nd;
      nd = $urandom_range(4, 1);
      add_start();
      for (int k = 0; k < nd; k++) add_data(1'($urandom_range(1, 0)));
      add_res(-1);
      add_idle($urandom_range(6, 1));
    end

    running = 1'b1;
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      sb_q.push_back(plan[i]);
      reset           = plan[i].rst;
      bus.StartCoding = plan[i].start;
      bus.qmode       = plan[i].qm;
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
